// File: rtl/vend_pkg.sv
// Shared definitions for the product dispenser: FSM states, vend command codes,
// refund prices and the stock saturation helper.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_MOTOR     = 3'd2,
    ST_WAIT_DROP = 3'd3,
    ST_CHANGE    = 3'd4,
    ST_REFUND    = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE        = 2'b00,
    CMD_CHOC_A      = 2'b01,
    CMD_CHOC_B      = 2'b10,
    CMD_CHOC_A_RET2 = 2'b11
  } vend_cmd_e;

  localparam logic [3:0] PRICE_A      = 4'd5;
  localparam logic [3:0] PRICE_B      = 4'd10;
  localparam logic [3:0] PRICE_A_RET2 = 4'd12;

  function automatic logic [3:0] refund_price(input vend_cmd_e cmd);
    logic [3:0] price;
    case (cmd)
      CMD_CHOC_A:      price = PRICE_A;
      CMD_CHOC_B:      price = PRICE_B;
      CMD_CHOC_A_RET2: price = PRICE_A_RET2;
      default:         price = 4'd0;
    endcase
    return price;
  endfunction

  // The sum is formed at 5 bits so a 4-bit wrap can never slip under the ceiling.
  function automatic logic [3:0] sat_add(input logic [3:0] stock,
                                         input logic [3:0] qty,
                                         input logic [4:0] ceiling);
    logic [4:0] sum;
    sum = {1'b0, stock} + {1'b0, qty};
    return (sum > ceiling) ? ceiling[3:0] : sum[3:0];
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the motor pulse length and the drop timeout.
module vend_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/dispense_controller.sv
// Two-product dispenser controller: stock check, motor pulse, drop supervision
// with sticky jam, change/refund pulses and in-IDLE restocking.
module dispense_controller
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STOCK_MAX      = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] vend_cmd,
  input  logic       drop_sense,
  input  logic       restock_en,
  input  logic       restock_sel,
  input  logic [3:0] restock_qty,
  output logic       motor_a,
  output logic       motor_b,
  output logic       change_2,
  output logic       refund,
  output logic [3:0] refund_amt,
  output logic       done,
  output logic       busy,
  output logic       jam,
  output logic [3:0] stock_a,
  output logic [3:0] stock_b
);

  localparam int TMR_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] MOTOR_LOAD   = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] STOCK_CEIL = 5'(STOCK_MAX);

  state_e     state_q;
  vend_cmd_e  cmd_q;
  vend_cmd_e  cmd_in;
  logic       jam_q;
  logic [3:0] stock_q [2];
  logic       sel_b;
  logic [3:0] sel_stock;
  logic       check_fail;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;

  assign cmd_in     = vend_cmd_e'(vend_cmd);
  assign sel_b      = (cmd_q == CMD_CHOC_B);
  assign sel_stock  = sel_b ? stock_q[1] : stock_q[0];
  assign check_fail = jam_q || (sel_stock == 4'd0);

  // Index 0 is product A, index 1 is product B.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stock
      localparam logic IS_B = (gi == 1);
      logic [3:0] stk_q;
      logic [3:0] stk_d;

      always_comb begin
        stk_d = stk_q;
        if ((state_q == ST_IDLE) && restock_en && (restock_sel == IS_B)) begin
          stk_d = sat_add(stk_q, restock_qty, STOCK_CEIL);
        end else if ((state_q == ST_CHECK) && !check_fail && (sel_b == IS_B)) begin
          stk_d = stk_q - 4'd1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          stk_q <= STOCK_CEIL[3:0];
        end else begin
          stk_q <= stk_d;
        end
      end

      assign stock_q[gi] = stk_q;
    end
  endgenerate

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    case (state_q)
      ST_CHECK: begin
        if (!check_fail) begin
          tmr_load     = 1'b1;
          tmr_load_val = MOTOR_LOAD;
        end
      end
      ST_MOTOR: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = TIMEOUT_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT_DROP: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  vend_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk_i      (clock),
    .srst_i     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      jam_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_in != CMD_NONE) begin
            cmd_q   <= cmd_in;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK:  state_q <= check_fail ? ST_REFUND : ST_MOTOR;
        ST_MOTOR:  if (tmr_zero) state_q <= ST_WAIT_DROP;
        ST_WAIT_DROP: begin
          // A drop in the final timeout cycle still counts as a sale.
          if (drop_sense) begin
            state_q <= (cmd_q == CMD_CHOC_A_RET2) ? ST_CHANGE : ST_DONE;
          end else if (tmr_zero) begin
            jam_q   <= 1'b1;
            state_q <= ST_REFUND;
          end
        end
        ST_CHANGE: state_q <= ST_DONE;
        ST_REFUND: state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign motor_a    = (state_q == ST_MOTOR) && !sel_b;
  assign motor_b    = (state_q == ST_MOTOR) && sel_b;
  assign change_2   = (state_q == ST_CHANGE);
  assign refund     = (state_q == ST_REFUND);
  assign refund_amt = refund ? refund_price(cmd_q) : 4'd0;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign jam        = jam_q;
  assign stock_a    = stock_q[0];
  assign stock_b    = stock_q[1];

endmodule

// File: tb/tb_dispense_controller.sv
// Table-driven bench for dispense_controller; a negedge monitor scores each
// completed transaction against expectations queued when the command is driven.
module tb_dispense_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] vend_cmd;
  logic       drop_sense;
  logic       restock_en;
  logic       restock_sel;
  logic [3:0] restock_qty;
  logic       motor_a, motor_b, change_2, refund, done, busy, jam;
  logic [3:0] refund_amt, stock_a, stock_b;

  dispense_controller #(
    .MOTOR_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .STOCK_MAX      (15)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vend_cmd    (vend_cmd),
    .drop_sense  (drop_sense),
    .restock_en  (restock_en),
    .restock_sel (restock_sel),
    .restock_qty (restock_qty),
    .motor_a     (motor_a),
    .motor_b     (motor_b),
    .change_2    (change_2),
    .refund      (refund),
    .refund_amt  (refund_amt),
    .done        (done),
    .busy        (busy),
    .jam         (jam),
    .stock_a     (stock_a),
    .stock_b     (stock_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] cmd;
    int         drop_idx;
    logic       r_en;
    logic       r_sel;
    logic [3:0] r_qty;
    logic       noise;
    logic       exp_motor;
    logic       exp_refund;
    logic [3:0] exp_amt;
    logic       exp_change;
    logic       exp_jam;
    logic [3:0] mid_a, mid_b, fin_a, fin_b;
  } vec_t;

  typedef struct {
    int         ma, mb, nref, nchg;
    int         m_first, m_last, ref_rel, done_rel;
    logic [3:0] amt, sa, sb;
    logic       jam;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   cur_tx = 0;

  int         ma_cnt, mb_cnt, ref_cnt, chg_cnt, m_first, m_last, ref_rel, amt_leak, both_on;
  logic [3:0] amt_cap;

  always @(posedge clock) cyc++;

  function automatic void chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL tx%0d %s: got %0d, expected %0d", cur_tx, name, act, exp_v);
    end
  endfunction

  function automatic vec_t mk(input logic [1:0] cmd, input int drop, input logic r_en,
                              input logic r_sel, input logic [3:0] qty, input logic noise,
                              input logic motor, input logic rf, input logic [3:0] amt,
                              input logic chg, input logic jm, input logic [3:0] ma,
                              input logic [3:0] mb, input logic [3:0] fa, input logic [3:0] fb);
    vec_t v;
    v.cmd = cmd; v.drop_idx = drop; v.r_en = r_en; v.r_sel = r_sel; v.r_qty = qty;
    v.noise = noise; v.exp_motor = motor; v.exp_refund = rf; v.exp_amt = amt;
    v.exp_change = chg; v.exp_jam = jm; v.mid_a = ma; v.mid_b = mb; v.fin_a = fa; v.fin_b = fb;
    return v;
  endfunction

  task automatic clear_acc();
    ma_cnt = 0; mb_cnt = 0; ref_cnt = 0; chg_cnt = 0; m_first = -1; m_last = -1;
    ref_rel = -1; amt_leak = 0; both_on = 0; amt_cap = 4'd0;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      clear_acc();
    end else begin
      if (motor_a || motor_b) begin
        if (m_first < 0) m_first = cyc - t0;
        m_last = cyc - t0;
      end
      if (motor_a) ma_cnt++;
      if (motor_b) mb_cnt++;
      if (motor_a && motor_b) both_on++;
      if (refund) begin
        ref_cnt++;
        amt_cap = refund_amt;
        ref_rel = cyc - t0;
      end else if (refund_amt != 4'd0) begin
        amt_leak++;
      end
      if (change_2) chg_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("motor_a_cycles", ma_cnt, e.ma);
          chk("motor_b_cycles", mb_cnt, e.mb);
          chk("motor_first_cycle", m_first, e.m_first);
          chk("motor_last_cycle", m_last, e.m_last);
          chk("refund_pulses", ref_cnt, e.nref);
          chk("refund_amt", amt_cap, e.amt);
          chk("refund_cycle", ref_rel, e.ref_rel);
          chk("change_pulses", chg_cnt, e.nchg);
          chk("done_cycle", cyc - t0, e.done_rel);
          chk("stock_a", stock_a, e.sa);
          chk("stock_b", stock_b, e.sb);
          chk("jam", jam, e.jam);
          chk("amt_without_refund", amt_leak, 0);
          chk("both_motors", both_on, 0);
        end
        clear_acc();
      end
    end
  end

  task automatic apply_vend(input vec_t v);
    exp_t e;
    e.ma       = (v.exp_motor && v.cmd != 2'b10) ? 4 : 0;
    e.mb       = (v.exp_motor && v.cmd == 2'b10) ? 4 : 0;
    e.m_first  = v.exp_motor ? 2 : -1;
    e.m_last   = v.exp_motor ? 5 : -1;
    e.nref     = v.exp_refund ? 1 : 0;
    e.amt      = v.exp_amt;
    e.nchg     = v.exp_change ? 1 : 0;
    e.ref_rel  = !v.exp_refund ? -1 : (v.exp_motor ? 22 : 2);
    e.done_rel = !v.exp_motor ? 3 :
                 (v.drop_idx < 0 ? 23 : 7 + v.drop_idx + ((v.cmd == 2'b11) ? 1 : 0));
    e.sa  = v.fin_a;
    e.sb  = v.fin_b;
    e.jam = v.exp_jam;
    if (v.cmd != 2'b00) sb_q.push_back(e);
    @(posedge clock); #1;
    cur_tx++;
    t0 = cyc;
    vend_cmd = v.cmd; restock_en = v.r_en; restock_sel = v.r_sel; restock_qty = v.r_qty;
    @(posedge clock); #1;
    vend_cmd = 2'b00; restock_en = 1'b0;
    @(negedge clock);
    chk("check_stock_a", stock_a, v.mid_a);
    chk("check_stock_b", stock_b, v.mid_b);
    if (v.cmd == 2'b00) return;
    for (int c = 2; c <= 25; c++) begin
      @(posedge clock); #1;
      drop_sense = (v.drop_idx >= 0) && (c == 6 + v.drop_idx);
      vend_cmd = 2'b00; restock_en = 1'b0;
      if (v.noise && c == 3) begin
        drop_sense = 1'b1; vend_cmd = 2'b10;
        restock_en = 1'b1; restock_sel = 1'b0; restock_qty = 4'd3;
      end
    end
    @(negedge clock);
    chk("idle_after_tx", busy, 0);
  endtask

  task automatic check_idle_outputs(input int sa, input int sb);
    chk("rst_busy", busy, 0);
    chk("rst_jam", jam, 0);
    chk("rst_motor_a", motor_a, 0);
    chk("rst_motor_b", motor_b, 0);
    chk("rst_change_2", change_2, 0);
    chk("rst_refund", refund, 0);
    chk("rst_refund_amt", refund_amt, 0);
    chk("rst_done", done, 0);
    chk("rst_stock_a", stock_a, sa);
    chk("rst_stock_b", stock_b, sb);
  endtask

  task automatic reset_dut();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; vend_cmd = 2'b00; drop_sense = 1'b0;
    restock_en = 1'b0; restock_sel = 1'b0; restock_qty = 4'd0;
    clear_acc();
    reset_dut();
    check_idle_outputs(15, 15);

    //             cmd drop en sel qty nz mot ref amt chg jam midA midB finA finB
    tbl.push_back(mk(2'b01,  1, 0, 0,  0, 0, 1, 0,  0, 0, 0, 15, 15, 14, 15));
    tbl.push_back(mk(2'b11,  0, 0, 0,  0, 0, 1, 0,  0, 1, 0, 14, 15, 13, 15));
    tbl.push_back(mk(2'b10,  3, 0, 0,  0, 0, 1, 0,  0, 0, 0, 13, 15, 13, 14));
    tbl.push_back(mk(2'b01, 15, 0, 0,  0, 0, 1, 0,  0, 0, 0, 13, 14, 12, 14));
    tbl.push_back(mk(2'b00, -1, 1, 0,  1, 0, 0, 0,  0, 0, 0, 13, 14, 13, 14));
    tbl.push_back(mk(2'b01,  2, 1, 0,  5, 0, 1, 0,  0, 0, 0, 15, 14, 14, 14));
    tbl.push_back(mk(2'b00, -1, 1, 1, 15, 0, 0, 0,  0, 0, 0, 14, 15, 14, 15));
    tbl.push_back(mk(2'b10,  0, 1, 1,  0, 0, 1, 0,  0, 0, 0, 14, 15, 14, 14));
    tbl.push_back(mk(2'b01,  4, 0, 0,  0, 1, 1, 0,  0, 0, 0, 14, 14, 13, 14));
    foreach (tbl[i]) apply_vend(tbl[i]);

    // Drain product B to empty, then a sold-out request.
    for (int i = 0; i < 14; i++) begin
      apply_vend(mk(2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                    4'd13, 4'(14 - i), 4'd13, 4'(13 - i)));
    end
    apply_vend(mk(2'b10, -1, 0, 0, 0, 0, 0, 1, 10, 0, 0, 13, 0, 13, 0));

    // Timeout jams; afterwards every command is refunded without running a motor.
    apply_vend(mk(2'b01, -1, 0, 0, 0, 0, 1, 1,  5, 0, 1, 13, 0, 12, 0));
    apply_vend(mk(2'b01, -1, 0, 0, 0, 0, 0, 1,  5, 0, 1, 12, 0, 12, 0));
    apply_vend(mk(2'b11, -1, 0, 0, 0, 0, 0, 1, 12, 0, 1, 12, 0, 12, 0));
    apply_vend(mk(2'b10, -1, 1, 1, 4, 0, 0, 1, 10, 0, 1, 12, 4, 12, 4));
    repeat (3) @(negedge clock);
    chk("jam_sticky", jam, 1);

    reset_dut();
    check_idle_outputs(15, 15);

    // Reset in the middle of a motor pulse.
    @(posedge clock); #1;
    cur_tx++;
    t0 = cyc;
    vend_cmd = 2'b01;
    @(posedge clock); #1;
    vend_cmd = 2'b00;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_motor_a", motor_a, 1);
    chk("mid_stock_a", stock_a, 14);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs(15, 15);

    apply_vend(mk(2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 15, 15, 14, 15));

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
